// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_pkg
//  Purpose  : Shared state encoding and default width for the bit-serial adder.
//  Revision : 1.0  initial release
// ============================================================================
package serial_adder_pkg;

   // Default operand/result width.
   localparam int SA_WIDTH_DEF = 8;

   // Controller states, 2-bit encoding.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } sa_state_e;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/fadd_s.sv
`default_nettype none
// ============================================================================
//  Module   : fadd_s
//  Purpose  : Single-bit full adder cell, used as the bit-slice of the serial
//             adder.
//  Revision : 1.0  initial release
// ============================================================================
module fadd_s (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic c
);

   // Sum and majority carry of the three input bits.
   always_comb begin
      s = a ^ b ^ ci;
      c = (a & b) | (a & ci) | (b & ci);
   end

endmodule : fadd_s
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Bit-serial WIDTH-bit adder. Operands are latched on start and
//             processed LSB-first through one fadd_s cell, one bit per clock,
//             with a carry flop closing the loop. Result is published on entry
//             to the one-cycle DONE state.
//  Options  : SERIAL_ADDER_SUB_EN adds a 'sub' input selecting a - b.
//  Revision : 1.0  initial release
// ============================================================================
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = SA_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int              CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   sa_state_e        state_q, state_d;
   logic [WIDTH-1:0] shreg_a_q, shreg_a_d;
   logic [WIDTH-1:0] shreg_b_q, shreg_b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;
   logic             do_sub;
   logic             fa_s;
   logic             fa_c;

`ifdef SERIAL_ADDER_SUB_EN
   assign do_sub = sub;
`else
   assign do_sub = 1'b0;
`endif

   // Single bit-slice: current LSBs plus the carry flop.
   fadd_s u_fadd (
      .a  (shreg_a_q[0]),
      .b  (shreg_b_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .c  (fa_c)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; start is honoured in IDLE and in DONE (back-to-back).
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath next values: load on accept, shift one bit per SHIFT cycle,
   // publish the completed result on the last shift.
   always_comb begin
      shreg_a_d = shreg_a_q;
      shreg_b_d = shreg_b_q;
      acc_d     = acc_q;
      carry_d   = carry_q;
      cnt_d     = cnt_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
      if (accept) begin
         shreg_a_d = op_a;
         // Subtraction is a + ~b + 1: invert b here, the +1 enters via carry.
         shreg_b_d = do_sub ? ~op_b : op_b;
         carry_d   = do_sub;
         acc_d     = '0;
         cnt_d     = '0;
      end else if (state_q == ST_SHIFT) begin
         shreg_a_d = {1'b0, shreg_a_q[WIDTH-1:1]};
         shreg_b_d = {1'b0, shreg_b_q[WIDTH-1:1]};
         acc_d     = {fa_s, acc_q[WIDTH-1:1]};
         carry_d   = fa_c;
         cnt_d     = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_LAST) begin
            sum_d  = {fa_s, acc_q[WIDTH-1:1]};
            cout_d = fa_c;
         end
      end
   end

   // Datapath registers; reset clears everything including the held result.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_a_q <= '0;
         shreg_b_q <= '0;
         acc_q     <= '0;
         carry_q   <= 1'b0;
         cnt_q     <= '0;
         sum_q     <= '0;
         cout_q    <= 1'b0;
      end else begin
         shreg_a_q <= shreg_a_d;
         shreg_b_q <= shreg_b_d;
         acc_q     <= acc_d;
         carry_q   <= carry_d;
         cnt_q     <= cnt_d;
         sum_q     <= sum_d;
         cout_q    <= cout_d;
      end
   end

   assign busy = (state_q == ST_SHIFT);
   assign done = (state_q == ST_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Purpose  : Self-checking bench for serial_adder (WIDTH=8), directed cases
//             plus randomized operands against an arithmetic reference.
//  Options  : SERIAL_ADDER_SUB_EN enables the subtraction scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_adder;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   int               n_checks = 0;
   int               n_errors = 0;
   logic [WIDTH:0]   held;   // expected {cout,sum} currently on the outputs

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op_a  (op_a),
      .op_b  (op_b),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   // Reference: plain arithmetic on the operands.
   function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic s);
      logic [WIDTH-1:0] diff;
      if (s) begin
         diff = a - b;
         return {(a >= b), diff};
      end
      return {1'b0, a} + {1'b0, b};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present operands with start for one edge, then scramble the inputs.
   task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s);
      start = 1'b1;
      op_a  = a;
      op_b  = b;
      sub   = s;
      step();
      start = 1'b0;
      op_a  = WIDTH'($urandom);
      op_b  = WIDTH'($urandom);
      sub   = 1'($urandom);
   endtask

   // Follow an accepted operation through SHIFT to its DONE cycle.
   // inject_k >= 0 raises start (10+10) during that SHIFT cycle.
   task automatic wait_done(input logic [WIDTH:0] exp, input int inject_k,
                            input string name);
      for (int k = 0; k < WIDTH; k++) begin
         n_checks++;
         if (busy !== 1'b1 || done !== 1'b0 || {cout, sum} !== held) begin
            n_errors++;
            $display("FAIL %s shift%0d: busy=%b done=%b res=%h, need busy=1 done=0 res=%h",
                     name, k, busy, done, {cout, sum}, held);
         end
         if (k == inject_k) begin
            start = 1'b1;
            op_a  = 8'h10;
            op_b  = 8'h10;
            sub   = 1'b0;
         end
         step();
         start = 1'b0;
      end
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || {cout, sum} !== exp) begin
         n_errors++;
         $display("FAIL %s done: done=%b busy=%b res=%h, need done=1 busy=0 res=%h",
                  name, done, busy, {cout, sum}, exp);
      end
      held = exp;
   endtask

   // One idle cycle: no pulse, result held.
   task automatic check_idle(input string name);
      start = 1'b0;
      step();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || {cout, sum} !== held) begin
         n_errors++;
         $display("FAIL %s idle: done=%b busy=%b res=%h, need done=0 busy=0 res=%h",
                  name, done, busy, {cout, sum}, held);
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b1;
      op_a  = 8'h35;
      op_b  = 8'h4A;
      sub   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         start = ~start;
         n_checks++;
         if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            n_errors++;
            $display("FAIL reset%0d: busy=%b done=%b sum=%h cout=%b, need all 0",
                     i, busy, done, sum, cout);
         end
      end
      rst   = 1'b0;
      start = 1'b0;
      held  = '0;
      check_idle("reset_release");
   endtask

   task automatic test_basic_add();
      accept(8'h35, 8'h4A, 1'b0);
      wait_done({1'b0, 8'h7F}, -1, "basic");
      check_idle("basic_hold1");
      check_idle("basic_hold2");
   endtask

   task automatic test_carry();
      accept(8'hFF, 8'h01, 1'b0);
      wait_done({1'b1, 8'h00}, -1, "ff_plus_01");
      check_idle("ff_plus_01");
      accept(8'hFF, 8'hFF, 1'b0);
      wait_done({1'b1, 8'hFE}, -1, "ff_plus_ff");
      check_idle("ff_plus_ff");
   endtask

   // Ends in the DONE cycle so test_back_to_back can start from there.
   task automatic test_ignored_start();
      accept(8'h01, 8'h01, 1'b0);
      wait_done({1'b0, 8'h02}, 3, "ignored_start");
   endtask

   task automatic test_back_to_back();
      accept(8'h10, 8'h10, 1'b0);
      wait_done({1'b0, 8'h20}, -1, "back_to_back");
      check_idle("back_to_back");
   endtask

   task automatic test_abort();
      accept(8'h35, 8'h4A, 1'b0);
      for (int i = 0; i < 4; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
         n_errors++;
         $display("FAIL abort: busy=%b done=%b sum=%h cout=%b, need all 0",
                  busy, done, sum, cout);
      end
      held = '0;
      for (int i = 0; i < 3; i++) check_idle("abort_quiet");
      accept(8'h0F, 8'h01, 1'b0);
      wait_done({1'b0, 8'h10}, -1, "after_abort");
      check_idle("after_abort");
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] a, b;
      logic             s;
      for (int i = 0; i < 24; i++) begin
         a = WIDTH'($urandom);
         b = WIDTH'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
         s = 1'($urandom);
`else
         s = 1'b0;
`endif
         accept(a, b, s);
         wait_done(model(a, b, s), -1, "random");
         // Randomly either chain from DONE or drop back to IDLE.
         if ($urandom_range(0, 1) == 0) check_idle("random");
      end
      check_idle("random_end");
   endtask

`ifdef SERIAL_ADDER_SUB_EN
   task automatic test_sub();
      accept(8'h10, 8'h03, 1'b1);
      wait_done({1'b1, 8'h0D}, -1, "sub_10_03");
      check_idle("sub_10_03");
      accept(8'h03, 8'h10, 1'b1);
      wait_done({1'b0, 8'hF3}, -1, "sub_03_10");
      check_idle("sub_03_10");
      accept(8'h35, 8'h4A, 1'b0);
      wait_done({1'b0, 8'h7F}, -1, "sub0_add");
      check_idle("sub0_add");
   endtask
`endif

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      op_a  = '0;
      op_b  = '0;
      sub   = 1'b0;
      held  = '0;
      test_reset();
      test_basic_add();
      test_carry();
      test_ignored_start();
      test_back_to_back();
      test_abort();
`ifdef SERIAL_ADDER_SUB_EN
      test_sub();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_serial_adder
`default_nettype wire
